snn_step_sched: RTL and testbench
=================================

# snn_step_sched

Timestep sequencer for `snn_core`. It replaces bench-driven stepping with hardware control. Per run it pulls one event vector per timestep from an upstream stream, applies it to the core, and captures and streams out the spike row. When learning is enabled it runs one full STDP weight scan per timestep. At end of run it can stream out the learned weights through the core's readback port.

## Interface
Parameters:
- `F`, 48, input feature count (event vector width)
- `N`, 96, neuron count (spike vector width)
- `AW`, `$clog2(F*N)`, weight address width
- `CORE_LAT`, 1, cycles from `core_event_vec` change to valid `core_spikes`

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  run request pulse; sampled only in IDLE
- `num_steps`  in  16  timesteps T; sampled on accepted `start`
- `learn_en`  in  1  STDP scan per step; sampled on accepted `start`
- `dump_en`  in  1  weight dump after last step; sampled on accepted `start`
- `ev_valid` / `ev_ready` / `ev_data`  in / out / in  1 / 1 / F  event stream
- `core_event_vec`  out  F  to `snn_core.event_vec`
- `core_spikes`  in  N  from `snn_core.spikes_vec`
- `stdp_enable`  out  1  to core
- `stdp_pre_bits`  out  F  to core
- `stdp_post_bits`  out  N  to core
- `rb_addr`  out  AW  to core readback
- `rb_data`  in  16 signed  from core; synchronous read, valid 1 cycle after `rb_addr`
- `sp_valid` / `sp_ready` / `sp_data`  out / in / out  1 / 1 / N  spike-row stream
- `wo_valid` / `wo_ready` / `wo_addr` / `wo_data`  out / in / out / out  1 / 1 / AW / 16  weight-dump stream
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse at run completion
- `step_cnt`  out  16  index of the current timestep

## Operation
- States: IDLE, FETCH, APPLY, EMIT, LEARN, GAP, DUMP_RD, DUMP_OUT, DONE.
- IDLE → FETCH on `start`. Before entering FETCH, the block latches `num_steps`, `learn_en` and `dump_en`, and clears `step_cnt`.
  - If `num_steps==0`, IDLE goes to DUMP_RD when `dump_en` is set, otherwise to DONE.
- FETCH: `ev_ready=1`. On `ev_valid&&ev_ready`, `core_event_vec<=ev_data` → APPLY.
- APPLY: `core_event_vec` is held for `CORE_LAT` cycles. On the final cycle, `core_spikes` is captured into the spike register → EMIT.
- EMIT: `sp_valid=1` and `sp_data` = the spike register. After the handshake completes:
  - → LEARN if `learn_en`;
  - otherwise → next-step decision.
- LEARN: `stdp_pre_bits` = `core_event_vec` and `stdp_post_bits` = the spike register, both held stable. `stdp_enable=1` for exactly F*N cycles, timed by the scan counter running 0..F*N-1. Then → GAP.
- GAP: `stdp_enable=0` for 1 cycle → next-step decision.
- Next-step decision:
  - If `step_cnt==T-1`, → DUMP_RD when `dump_en`, otherwise → DONE.
  - Otherwise `step_cnt++` → FETCH.
- DUMP_RD: drive `rb_addr` = dump address and wait 1 cycle → DUMP_OUT.
- DUMP_OUT: `wo_valid=1`, `wo_addr` = dump address, `wo_data` = `rb_data` registered at entry to DUMP_OUT. After the handshake:
  - if the address was F*N-1, → DONE;
  - otherwise address++ → DUMP_RD.
- DONE: `done=1` for 1 cycle → IDLE. `core_event_vec` clears to 0.
- `start` is ignored while `busy`.

## Timing
- Reset values:
  - state IDLE; all valid and ready outputs 0; `stdp_enable=0`; `done=0`; `busy=0`
  - `core_event_vec`, `stdp_pre_bits`, `stdp_post_bits`, `sp_data`, `rb_addr`, `wo_addr`, `wo_data` and `step_cnt` all 0
- A reset asserted mid-run returns the block to IDLE immediately, including mid-LEARN. No partial-row or partial-dump output is emitted. Any weights the core already updated are not restored.
- Minimum cycles per step, with zero-wait handshakes:
  - without learning: 1 (FETCH) + `CORE_LAT` + 1 (EMIT);
  - with learning: add F*N + 1.
- Dump: 2 cycles per word at minimum.
- Backpressure: `sp_data`, `wo_data` and `wo_addr` stay stable while valid is high and ready is low. Valid never drops without a handshake.
- `stdp_enable` is never high outside LEARN.
- `stdp_pre_bits` and `stdp_post_bits` change only in EMIT, so they are stable through all of LEARN.
- `ev_ready` is high only in FETCH. The upstream stream may stall indefinitely.
- Counter widths:
  - scan counter and dump address are AW bits; compare against F*N-1, never wrap;
  - `step_cnt` is 16 bits; T=65535 is legal.

## Test plan
- Reset: `rst` pulse → all outputs 0, `busy=0`; `start` held during reset → no effect.
- T=3, `learn_en=0`, CORE_LAT=1, `ev_valid` always high, `sp_ready` always high:
  - 3 `sp_valid` pulses spaced 3 cycles apart;
  - `sp_data` equals the model spikes for events 0, 1, 2;
  - `done` 1 cycle after the 3rd row; `stdp_enable` never high.
- T=2 with `learn_en=1`:
  - `stdp_enable` high for exactly 4608 consecutive cycles per step, with 1 low GAP cycle between scans;
  - `stdp_pre_bits` equals the applied event and `stdp_post_bits` equals the captured spikes throughout each scan.
- Backpressure: hold `sp_ready=0` for 10 cycles mid-run → `sp_data` stays stable, state stays in EMIT, no fetch occurs; release → run resumes normally.
- Dump with T=0 and `dump_en=1`, using a core model returning `rb_data=addr` with 1-cycle latency:
  - 4608 words with `wo_data==wo_addr` for addresses 0..4607;
  - random `wo_ready` stalls cause no duplicated or skipped address.
- Assert `rst` mid-LEARN at scan index 1000 → `stdp_enable` drops immediately; a subsequent `start` runs the full T steps from `step_cnt=0`.

Source files
------------

// File: rtl/snn_step_sched_if.sv
// Stream bundle for snn_step_sched: event input, spike-row output and weight-dump output.
// The master side is the sequencer; the slave side is the surrounding fabric.
interface snn_step_sched_if #(
  parameter int F  = 48,
  parameter int N  = 96,
  parameter int AW = $clog2(F*N)
);
  logic          ev_valid;
  logic          ev_ready;
  logic [F-1:0]  ev_data;
  logic          sp_valid;
  logic          sp_ready;
  logic [N-1:0]  sp_data;
  logic          wo_valid;
  logic          wo_ready;
  logic [AW-1:0] wo_addr;
  logic [15:0]   wo_data;

  modport master (
    input  ev_valid, ev_data, sp_ready, wo_ready,
    output ev_ready, sp_valid, sp_data, wo_valid, wo_addr, wo_data
  );

  modport slave (
    output ev_valid, ev_data, sp_ready, wo_ready,
    input  ev_ready, sp_valid, sp_data, wo_valid, wo_addr, wo_data
  );
endinterface

// File: rtl/snn_step_sched.sv
// Timestep sequencer for snn_core: fetches one event vector per step, captures and streams
// the spike row, optionally runs a full STDP scan per step and dumps the weights at the end.
module snn_step_sched #(
  parameter int F        = 48,
  parameter int N        = 96,
  parameter int AW       = $clog2(F*N),
  parameter int CORE_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  snn_step_sched_if.master    io,
  input  logic                start,
  input  logic [15:0]         num_steps,
  input  logic                learn_en,
  input  logic                dump_en,
  output logic [F-1:0]        core_event_vec,
  input  logic [N-1:0]        core_spikes,
  output logic                stdp_enable,
  output logic [F-1:0]        stdp_pre_bits,
  output logic [N-1:0]        stdp_post_bits,
  output logic [AW-1:0]       rb_addr,
  input  logic signed [15:0]  rb_data,
  output logic                busy,
  output logic                done,
  output logic [15:0]         step_cnt
);

  localparam logic [AW-1:0] LAST     = AW'(F*N-1);
  localparam int            LW       = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(CORE_LAT-1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_APPLY, S_EMIT, S_LEARN, S_GAP, S_DUMP_RD, S_DUMP_OUT, S_DONE
  } state_t;

  state_t        state, next;
  logic [15:0]   t_last;
  logic          learn_r;
  logic          dump_r;
  logic [LW-1:0] lat_cnt;
  logic [AW-1:0] scan_cnt;
  logic [AW-1:0] dump_addr;
  logic [N-1:0]  spike_r;
  logic [15:0]   wo_data_r;
  logic          last_step;
  state_t        step_next;

  assign last_step = (step_cnt == t_last);
  assign step_next = last_step ? (dump_r ? S_DUMP_RD : S_DONE) : S_FETCH;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  // Next-state logic
  always_comb begin
    next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_steps == 16'd0) next = dump_en ? S_DUMP_RD : S_DONE;
          else                    next = S_FETCH;
        end else begin
          next = S_IDLE;
        end
      end
      S_FETCH:    next = io.ev_valid ? S_APPLY : S_FETCH;
      S_APPLY:    next = (lat_cnt == LAT_LAST) ? S_EMIT : S_APPLY;
      S_EMIT: begin
        if (io.sp_ready) next = learn_r ? S_LEARN : step_next;
        else             next = S_EMIT;
      end
      S_LEARN:    next = (scan_cnt == LAST) ? S_GAP : S_LEARN;
      S_GAP:      next = step_next;
      S_DUMP_RD:  next = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (io.wo_ready) next = (dump_addr == LAST) ? S_DONE : S_DUMP_RD;
        else             next = S_DUMP_OUT;
      end
      S_DONE:     next = S_IDLE;
      default:    next = S_IDLE;
    endcase
  end

  assign io.ev_ready = (state == S_FETCH);
  assign io.sp_valid = (state == S_EMIT);
  assign io.sp_data  = spike_r;
  assign io.wo_valid = (state == S_DUMP_OUT);
  assign io.wo_addr  = dump_addr;
  assign io.wo_data  = wo_data_r;
  assign stdp_enable = (state == S_LEARN);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  // The read port is pointed at the next word while the current one is offered, so the
  // synchronous read has already landed when DUMP_RD registers it.
  assign rb_addr = (state == S_DUMP_OUT && dump_addr != LAST) ? dump_addr + AW'(1) : dump_addr;

  // Datapath registers: run configuration, event/spike capture, scan and dump counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_last         <= 16'd0;
      learn_r        <= 1'b0;
      dump_r         <= 1'b0;
      lat_cnt        <= '0;
      scan_cnt       <= '0;
      dump_addr      <= '0;
      spike_r        <= '0;
      wo_data_r      <= 16'd0;
      core_event_vec <= '0;
      stdp_pre_bits  <= '0;
      stdp_post_bits <= '0;
      step_cnt       <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            t_last    <= num_steps - 16'd1;
            learn_r   <= learn_en;
            dump_r    <= dump_en;
            step_cnt  <= 16'd0;
            dump_addr <= '0;
          end
        end
        S_FETCH: begin
          if (io.ev_valid) begin
            core_event_vec <= io.ev_data;
            lat_cnt        <= '0;
          end
        end
        S_APPLY: begin
          if (lat_cnt == LAT_LAST) spike_r <= core_spikes;
          else                     lat_cnt <= lat_cnt + LW'(1);
        end
        S_EMIT: begin
          if (io.sp_ready) begin
            stdp_pre_bits  <= core_event_vec;
            stdp_post_bits <= spike_r;
            scan_cnt       <= '0;
            if (!learn_r && !last_step) step_cnt <= step_cnt + 16'd1;
          end
        end
        S_LEARN: begin
          if (scan_cnt != LAST) scan_cnt <= scan_cnt + AW'(1);
        end
        S_GAP: begin
          if (!last_step) step_cnt <= step_cnt + 16'd1;
        end
        S_DUMP_RD: wo_data_r <= rb_data;
        S_DUMP_OUT: begin
          if (io.wo_ready && dump_addr != LAST) dump_addr <= dump_addr + AW'(1);
        end
        S_DONE: begin
          core_event_vec <= '0;
          dump_addr      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_step_sched.sv
// Self-checking bench for snn_step_sched: directed runs with randomized events and stalls,
// compared against a queue-based reference of what each run must produce.
module tb_snn_step_sched;
  localparam int F        = 48;
  localparam int N        = 96;
  localparam int AW       = $clog2(F*N);
  localparam int CORE_LAT = 1;
  localparam int FN       = F*N;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [15:0]        num_steps;
  logic               learn_en;
  logic               dump_en;
  logic [F-1:0]       core_event_vec;
  logic [N-1:0]       core_spikes;
  logic               stdp_enable;
  logic [F-1:0]       stdp_pre_bits;
  logic [N-1:0]       stdp_post_bits;
  logic [AW-1:0]      rb_addr;
  logic signed [15:0] rb_data;
  logic               busy;
  logic               done;
  logic [15:0]        step_cnt;

  int n_cmp = 0;
  int n_err = 0;

  snn_step_sched_if #(.F(F), .N(N), .AW(AW)) bus();

  snn_step_sched #(.F(F), .N(N), .AW(AW), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst(rst), .io(bus), .start(start), .num_steps(num_steps),
    .learn_en(learn_en), .dump_en(dump_en), .core_event_vec(core_event_vec),
    .core_spikes(core_spikes), .stdp_enable(stdp_enable), .stdp_pre_bits(stdp_pre_bits),
    .stdp_post_bits(stdp_post_bits), .rb_addr(rb_addr), .rb_data(rb_data),
    .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_spikes(input logic [F-1:0] e);
    return {~e, e[23:0], e[47:24]};
  endfunction

  function automatic logic [F-1:0] rand_ev();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[F-1:0];
  endfunction

  // Core stand-in: spikes follow the applied event; readback returns the address one cycle later.
  assign core_spikes = model_spikes(core_event_vec);
  always_ff @(posedge clk) rb_data <= 16'(rb_addr);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int t, input bit learn, input bit dump, input bit ev_rand,
                     input int stall_row, input bit wo_rand, input int abort_scan,
                     input int budget, output bit aborted);
    logic [F-1:0]  applied_q[$];
    int            p[$];
    logic [N-1:0]  held_sp;
    logic [AW-1:0] held_addr;
    logic [15:0]   held_data;
    logic [F-1:0]  cur;
    int rows = 0, fed = 0, words = 0, runs = 0, scan_len = 0, viol = 0, stall_n = 0;
    int prev_end = -1, done_cyc = -1;
    bit ev_used = 1'b0, in_scan = 1'b0, wo_pend = 1'b0;
    aborted = 1'b0;
    held_sp = '0; held_addr = '0; held_data = 16'd0;
    start = 1'b1; num_steps = 16'(t); learn_en = learn; dump_en = dump;
    bus.ev_valid = 1'b0; bus.sp_ready = 1'b1; bus.wo_ready = 1'b0; bus.ev_data = rand_ev();
    @(negedge clk);
    num_steps = 16'($urandom); learn_en = !learn; dump_en = !dump;
    for (int cyc = 0; cyc < budget; cyc++) begin
      start = (cyc < 3);
      if (cyc == 0) check("busy_run", busy, 1);
      if (ev_used) begin bus.ev_data = rand_ev(); ev_used = 1'b0; end
      bus.ev_valid = ev_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.ev_ready && bus.ev_valid) begin
        applied_q.push_back(bus.ev_data); fed++; ev_used = 1'b1;
      end
      bus.sp_ready = !(rows == stall_row && stall_n < 10);
      if (bus.sp_valid) begin
        if (!bus.sp_ready) begin
          if (stall_n == 0) held_sp = bus.sp_data;
          else check("sp_stable", bus.sp_data, held_sp);
          check("no_fetch", bus.ev_ready, 0);
          stall_n++;
        end else begin
          check("sp_data", bus.sp_data,
                (rows < applied_q.size()) ? model_spikes(applied_q[rows]) : '1);
          check("step_cnt", step_cnt, rows);
          p.push_back(cyc); rows++;
        end
      end
      if (stdp_enable) begin
        if (!in_scan) begin
          in_scan = 1'b1; scan_len = 0; viol = 0;
          if (runs > 0 && !ev_rand) check("scan_gap", cyc - prev_end, 3 + CORE_LAT);
        end
        cur = (runs < applied_q.size()) ? applied_q[runs] : '0;
        if (stdp_pre_bits !== cur || stdp_post_bits !== model_spikes(cur)) viol++;
        scan_len++;
        if (abort_scan > 0 && scan_len == abort_scan) begin aborted = 1'b1; return; end
      end else if (in_scan) begin
        in_scan = 1'b0;
        check("scan_len", scan_len, FN);
        check("scan_bits", viol, 0);
        prev_end = cyc; runs++;
      end
      bus.wo_ready = wo_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wo_pend) begin
        check("wo_hold", bus.wo_valid, 1);
        check("wo_addr_stable", bus.wo_addr, held_addr);
        check("wo_data_stable", bus.wo_data, held_data);
      end
      if (bus.wo_valid) begin
        if (bus.wo_ready) begin
          check("dump_addr", bus.wo_addr, words);
          check("dump_data", bus.wo_data, words);
          words++; wo_pend = 1'b0;
        end else begin
          wo_pend = 1'b1; held_addr = bus.wo_addr; held_data = bus.wo_data;
        end
      end else begin
        wo_pend = 1'b0;
      end
      if (done) begin done_cyc = cyc; break; end
      @(negedge clk);
    end
    start = 1'b0; bus.ev_valid = 1'b0; bus.wo_ready = 1'b0; bus.sp_ready = 1'b1;
    check("done_seen", done_cyc >= 0, 1);
    check("rows", rows, t);
    check("fetched", fed, t);
    check("scans", runs, learn ? t : 0);
    check("words", words, dump ? FN : 0);
    if (done_cyc >= 0 && !ev_rand && stall_row < 0 && !dump && t > 0) begin
      for (int i = 1; i < p.size(); i++)
        check("row_spacing", p[i] - p[i-1], learn ? (2 + CORE_LAT + FN + 1) : (2 + CORE_LAT));
      check("done_lat", done_cyc, learn ? (prev_end + 1) : (p[p.size()-1] + 1));
    end
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_ev", core_event_vec, 0);
  endtask

  initial begin
    bit ab;
    rst = 1'b1; start = 1'b1; num_steps = 16'd5; learn_en = 1'b0; dump_en = 1'b0;
    bus.ev_valid = 1'b1; bus.ev_data = rand_ev(); bus.sp_ready = 1'b1; bus.wo_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ev_ready", bus.ev_ready, 0);
    check("rst_sp_valid", bus.sp_valid, 0);
    check("rst_wo_valid", bus.wo_valid, 0);
    check("rst_stdp_en", stdp_enable, 0);
    check("rst_core_ev", core_event_vec, 0);
    check("rst_sp_data", bus.sp_data, 0);
    check("rst_wo_addr", bus.wo_addr, 0);
    check("rst_wo_data", bus.wo_data, 0);
    check("rst_rb_addr", rb_addr, 0);
    check("rst_pre", stdp_pre_bits, 0);
    check("rst_post", stdp_post_bits, 0);
    check("rst_step", step_cnt, 0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Plain run, zero-wait handshakes
    run(3, 1'b0, 1'b0, 1'b0, -1, 1'b0, 0, 60, ab);
    // Spike-row backpressure on the second row, stalling upstream
    run(4, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 300, ab);
    // Learning run: one full scan per step
    run(2, 1'b1, 1'b0, 1'b0, -1, 1'b0, 0, 12000, ab);
    // Weight dump only, random dump-side stalls
    run(0, 1'b0, 1'b1, 1'b0, -1, 1'b1, 0, 25000, ab);
    // Reset in the middle of a scan, then a fresh run
    run(3, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1001, 6000, ab);
    check("abort_reached", ab, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_stdp", stdp_enable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_step", step_cnt, 0);
    check("mid_rst_pre", stdp_pre_bits, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    run(3, 1'b0, 1'b0, 1'b0, -1, 1'b0, 0, 60, ab);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
